// File: rtl/tl_cpl_tx_packer.sv
// rtl/tl_cpl_tx_packer.sv - completion TLP packer: 3-DW header plus realigned payload onto a 256-bit stream
module tl_cpl_tx_packer #(
  parameter int MAX_CPLD_PAYLOAD = 256,
  parameter int LEN_W            = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] cpl_hdr_i,
  input  logic         cpl_has_data_i,
  input  logic         cpl_hdr_valid_i,
  output logic         cpl_hdr_ready_o,
  input  logic [255:0] cpl_data_i,
  input  logic         cpl_data_valid_i,
  output logic         cpl_data_ready_o,
  output logic [255:0] tx_data_o,
  output logic [7:0]   tx_keep_o,
  output logic         tx_sop_o,
  output logic         tx_eop_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic         len_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_BODY,
    ST_TAIL
  } state_t;

  state_t             state_q, state_d;
  logic [95:0]        hdr_q, hdr_d;
  logic [95:0]        carry_q, carry_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [255:0]       tx_data_q, tx_data_d;
  logic [7:0]         tx_keep_q, tx_keep_d;
  logic               tx_sop_q, tx_sop_d;
  logic               tx_eop_q, tx_eop_d;
  logic               tx_valid_q, tx_valid_d;
  logic               len_err_q, len_err_d;

  logic               adv;
  logic               hdr_fire;
  logic               data_fire;
  logic [9:0]         hdr_len10;
  logic [LEN_W-1:0]   hdr_len;
  logic [3:0]         take_first;
  logic [3:0]         take_body;
  logic [LEN_W-1:0]   rem_first;
  logic [LEN_W-1:0]   rem_body;
  logic [7:0]         keep_sel;
  logic               unused_hdr_low;

  // N ones packed from the MSB (bit 7 = DW0 of the beat)
  function automatic logic [7:0] keep_of(input logic [3:0] n);
    keep_of = ~(8'hFF >> n);
  endfunction

  // expand a DW keep vector into a 256-bit data mask
  function automatic logic [255:0] mask_of(input logic [7:0] k);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i*32 +: 32] = {32{k[i]}};
    end
    return m;
  endfunction

  // header low DW carries no information for the packer
  assign unused_hdr_low = ^cpl_hdr_i[31:0];

  // the output register can take a new beat when empty or being drained this cycle
  assign adv       = !tx_valid_q || tx_ready_i;
  assign cpl_hdr_ready_o  = (state_q == ST_IDLE) && adv;
  assign cpl_data_ready_o = ((state_q == ST_FIRST) || (state_q == ST_BODY)) && adv;
  assign hdr_fire  = cpl_hdr_valid_i && cpl_hdr_ready_o;
  assign data_fire = cpl_data_valid_i && cpl_data_ready_o;

  // a length field of zero encodes the maximum of 1024 DWs
  assign hdr_len10 = cpl_hdr_i[105:96];
  assign hdr_len   = (hdr_len10 == 10'd0) ? LEN_W'(1024) : LEN_W'(hdr_len10);

  // payload DWs consumed by the first beat (after the header) and by body beats
  assign take_first = (rem_q < LEN_W'(5)) ? rem_q[3:0] : 4'd5;
  assign take_body  = (rem_q < LEN_W'(8)) ? rem_q[3:0] : 4'd8;
  assign rem_first  = rem_q - LEN_W'(take_first);
  assign rem_body   = rem_q - LEN_W'(take_body);

  // next-state, carry realignment and output-register loading
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    carry_d    = carry_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_keep_d  = tx_keep_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    tx_valid_d = tx_valid_q;
    len_err_d  = 1'b0;
    keep_sel   = 8'h00;

    if (adv) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (hdr_fire) begin
          hdr_d     = cpl_hdr_i[127:32];
          len_err_d = (hdr_len > LEN_W'(MAX_CPLD_PAYLOAD));
          if (!cpl_has_data_i) begin
            tx_data_d  = {cpl_hdr_i[127:32], 160'd0};
            tx_keep_d  = 8'hE0;
            tx_sop_d   = 1'b1;
            tx_eop_d   = 1'b1;
            tx_valid_d = 1'b1;
          end else begin
            rem_d   = hdr_len;
            state_d = ST_FIRST;
          end
        end
      end

      ST_FIRST: begin
        if (data_fire) begin
          keep_sel   = keep_of(4'd3 + take_first);
          tx_data_d  = {hdr_q, cpl_data_i[255:96]} & mask_of(keep_sel);
          tx_keep_d  = keep_sel;
          tx_sop_d   = 1'b1;
          tx_eop_d   = (rem_first == '0);
          tx_valid_d = 1'b1;
          carry_d    = cpl_data_i[95:0];
          rem_d      = rem_first;
          if (rem_first == '0) begin
            state_d = ST_IDLE;
          end else if (rem_first <= LEN_W'(3)) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_BODY;
          end
        end
      end

      ST_BODY: begin
        if (data_fire) begin
          keep_sel   = keep_of(take_body);
          tx_data_d  = {carry_q, cpl_data_i[255:96]} & mask_of(keep_sel);
          tx_keep_d  = keep_sel;
          tx_sop_d   = 1'b0;
          tx_eop_d   = (rem_body == '0);
          tx_valid_d = 1'b1;
          carry_d    = cpl_data_i[95:0];
          rem_d      = rem_body;
          if (rem_body == '0) begin
            state_d = ST_IDLE;
          end else if (rem_body <= LEN_W'(3)) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_BODY;
          end
        end
      end

      ST_TAIL: begin
        if (adv) begin
          keep_sel   = keep_of(rem_q[3:0]);
          tx_data_d  = {carry_q, 160'd0} & mask_of(keep_sel);
          tx_keep_d  = keep_sel;
          tx_sop_d   = 1'b0;
          tx_eop_d   = 1'b1;
          tx_valid_d = 1'b1;
          rem_d      = '0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, carry and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      carry_q    <= '0;
      rem_q      <= '0;
      tx_data_q  <= '0;
      tx_keep_q  <= '0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      carry_q    <= carry_d;
      rem_q      <= rem_d;
      tx_data_q  <= tx_data_d;
      tx_keep_q  <= tx_keep_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_valid_q <= tx_valid_d;
      len_err_q  <= len_err_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_keep_o  = tx_keep_q;
  assign tx_sop_o   = tx_sop_q;
  assign tx_eop_o   = tx_eop_q;
  assign tx_valid_o = tx_valid_q;
  assign len_err_o  = len_err_q;

endmodule

// File: tb/tb_tl_cpl_tx_packer.sv
// tb/tb_tl_cpl_tx_packer.sv - scoreboard bench for tl_cpl_tx_packer
module tb_tl_cpl_tx_packer;

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   keep;
    logic         sop;
    logic         eop;
  } beat_t;

  logic         clk;
  logic         rst;
  logic [127:0] cpl_hdr_i;
  logic         cpl_has_data_i;
  logic         cpl_hdr_valid_i;
  logic         cpl_hdr_ready_o;
  logic [255:0] cpl_data_i;
  logic         cpl_data_valid_i;
  logic         cpl_data_ready_o;
  logic [255:0] tx_data_o;
  logic [7:0]   tx_keep_o;
  logic         tx_sop_o;
  logic         tx_eop_o;
  logic         tx_valid_o;
  logic         tx_ready_i;
  logic         len_err_o;

  int    tests_run;
  int    tests_failed;
  int    beat_cnt;
  int    err_cnt;
  logic  bp_en;
  beat_t exp_q[$];

  tl_cpl_tx_packer #(.MAX_CPLD_PAYLOAD(256), .LEN_W(11)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpl_hdr_i        (cpl_hdr_i),
    .cpl_has_data_i   (cpl_has_data_i),
    .cpl_hdr_valid_i  (cpl_hdr_valid_i),
    .cpl_hdr_ready_o  (cpl_hdr_ready_o),
    .cpl_data_i       (cpl_data_i),
    .cpl_data_valid_i (cpl_data_valid_i),
    .cpl_data_ready_o (cpl_data_ready_o),
    .tx_data_o        (tx_data_o),
    .tx_keep_o        (tx_keep_o),
    .tx_sop_o         (tx_sop_o),
    .tx_eop_o         (tx_eop_o),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .len_err_o        (len_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic logic [31:0] pdw(input int tag, input int idx);
    logic [7:0]  t;
    logic [23:0] i;
    t = tag[7:0];
    i = idx[23:0];
    return {t, i};
  endfunction

  function automatic logic [255:0] in_beat(input int tag, input int len, input int b);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      if (8 * b + j < len) r[255-32*j -: 32] = pdw(tag, 8 * b + j);
      else                 r[255-32*j -: 32] = 32'hDEAD0000 | 32'(j);
    end
    return r;
  endfunction

  // reference framing: header DWs followed by payload, cut into 8-DW beats
  task automatic push_tlp(input logic [95:0] h, input int len, input int tag);
    logic [31:0] dw[$];
    beat_t       bt;
    int          total;
    int          nb;
    dw.push_back(h[95:64]);
    dw.push_back(h[63:32]);
    dw.push_back(h[31:0]);
    for (int i = 0; i < len; i++) dw.push_back(pdw(tag, i));
    total = len + 3;
    nb    = (total + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      bt = '0;
      for (int j = 0; j < 8; j++) begin
        if (8 * b + j < total) begin
          bt.data[255-32*j -: 32] = dw[8*b+j];
          bt.keep[7-j]            = 1'b1;
        end
      end
      bt.sop = (b == 0);
      bt.eop = (b == nb - 1);
      exp_q.push_back(bt);
    end
  endtask

  task automatic send_hdr(input logic [95:0] h, input logic hd);
    logic ok;
    ok              = 1'b0;
    cpl_hdr_i       = {h, 32'hFFFF_FFFF};
    cpl_has_data_i  = hd;
    cpl_hdr_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpl_hdr_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cpl_hdr_valid_i = 1'b0;
    cpl_hdr_i       = '0;
    if (!ok) fail_timeout("hdr_handshake");
  endtask

  task automatic send_data(input logic [255:0] d);
    logic ok;
    ok               = 1'b0;
    cpl_data_i       = d;
    cpl_data_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpl_data_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cpl_data_valid_i = 1'b0;
    cpl_data_i       = '0;
    if (!ok) fail_timeout("data_handshake");
  endtask

  task automatic wait_drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) fail_timeout("drain");
  endtask

  task automatic run_cpld(input int len, input int tag, input int exp_beats, input int exp_err);
    logic [95:0] h;
    int          b0;
    int          e0;
    h  = {32'h4A000000 | (32'(len) & 32'h3FF), 32'h01000000 | 32'(tag), 32'h00AB0500 + 32'(tag)};
    b0 = beat_cnt;
    e0 = err_cnt;
    push_tlp(h, len, tag);
    send_hdr(h, 1'b1);
    for (int b = 0; b < (len + 7) / 8; b++) send_data(in_beat(tag, len, b));
    wait_drain();
    chk($sformatf("nbeats_L%0d", len), 256'(beat_cnt - b0), 256'(exp_beats));
    chk($sformatf("len_err_L%0d", len), 256'(err_cnt - e0), 256'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 256'(tx_valid_o), 256'(0));
    chk({tag, "_sop"}, 256'(tx_sop_o), 256'(0));
    chk({tag, "_eop"}, 256'(tx_eop_o), 256'(0));
    chk({tag, "_keep"}, 256'(tx_keep_o), 256'(0));
    chk({tag, "_data"}, tx_data_o, 256'(0));
    chk({tag, "_lenerr"}, 256'(len_err_o), 256'(0));
    chk({tag, "_hdr_rdy"}, 256'(cpl_hdr_ready_o), 256'(1));
    chk({tag, "_data_rdy"}, 256'(cpl_data_ready_o), 256'(0));
  endtask

  // output backpressure generator
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready_i = bp_en ? ~tx_ready_i : 1'b1;
    end
  end

  // monitor: pops the scoreboard on every accepted output beat, checks stall stability
  initial begin
    beat_t        e;
    logic         stalled;
    logic [255:0] s_data;
    logic [7:0]   s_keep;
    logic         s_sop;
    logic         s_eop;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (len_err_o) err_cnt++;
        if (tx_valid_o && !tx_ready_i) begin
          if (stalled) begin
            chk("stall_data", tx_data_o, s_data);
            chk("stall_keep", 256'(tx_keep_o), 256'(s_keep));
            chk("stall_sop_eop", 256'({tx_sop_o, tx_eop_o}), 256'({s_sop, s_eop}));
          end
          chk("stall_data_rdy", 256'(cpl_data_ready_o), 256'(0));
          chk("stall_hdr_rdy", 256'(cpl_hdr_ready_o), 256'(0));
          stalled = 1'b1;
          s_data  = tx_data_o;
          s_keep  = tx_keep_o;
          s_sop   = tx_sop_o;
          s_eop   = tx_eop_o;
        end else begin
          stalled = 1'b0;
        end
        if (tx_valid_o && tx_ready_i) begin
          beat_cnt++;
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_beat: got data %h keep %h sop %0d eop %0d, expected none",
                     tx_data_o, tx_keep_o, tx_sop_o, tx_eop_o);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", tx_data_o, e.data);
            chk("beat_keep", 256'(tx_keep_o), 256'(e.keep));
            chk("beat_sop", 256'(tx_sop_o), 256'(e.sop));
            chk("beat_eop", 256'(tx_eop_o), 256'(e.eop));
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    beat_t bt;
    tests_run        = 0;
    tests_failed     = 0;
    beat_cnt         = 0;
    err_cnt          = 0;
    bp_en            = 1'b0;
    rst              = 1'b1;
    cpl_hdr_i        = '0;
    cpl_has_data_i   = 1'b0;
    cpl_hdr_valid_i  = 1'b0;
    cpl_data_i       = '0;
    cpl_data_valid_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cpl without data, hand-written beat
    bt.data = 256'h0A000001_01000004_00AB0500_00000000_00000000_00000000_00000000_00000000;
    bt.keep = 8'hE0;
    bt.sop  = 1'b1;
    bt.eop  = 1'b1;
    exp_q.push_back(bt);
    send_hdr(96'h0A000001_01000004_00AB0500, 1'b0);
    wait_drain();

    // three back-to-back Cpls
    for (int k = 1; k <= 3; k++) begin
      bt.data = {32'h0A000000 | 32'(k), 32'h01000004, 32'h00AB0500, 160'd0};
      exp_q.push_back(bt);
    end
    for (int k = 1; k <= 3; k++) send_hdr({32'h0A000000 | 32'(k), 32'h01000004, 32'h00AB0500}, 1'b0);
    wait_drain();

    run_cpld(5, 8'h11, 1, 0);
    run_cpld(14, 8'h22, 3, 0);
    run_cpld(13, 8'h33, 2, 0);
    run_cpld(6, 8'h44, 2, 0);
    run_cpld(2, 8'h55, 1, 0);

    bp_en = 1'b1;
    run_cpld(14, 8'h66, 3, 0);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset after the first beat of an L=14 completion
    begin
      logic [95:0] h;
      h = {32'h4A00000E, 32'h01000077, 32'h00AB0577};
      push_tlp(h, 14, 8'h77);
      send_hdr(h, 1'b1);
      send_data(in_beat(8'h77, 14, 0));
      repeat (2) @(posedge clk);
      #1;
      chk("rst_first_beat_popped", 256'(exp_q.size()), 256'(2));
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    bt.data = {32'h0A0000AA, 32'h01000004, 32'h00AB0500, 160'd0};
    bt.keep = 8'hE0;
    bt.sop  = 1'b1;
    bt.eop  = 1'b1;
    exp_q.push_back(bt);
    send_hdr({32'h0A0000AA, 32'h01000004, 32'h00AB0500}, 1'b0);
    wait_drain();

    // length 0 encodes 1024 DWs, above the 256-DW limit
    run_cpld(1024, 8'h88, 129, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
